// File: rtl/inv_sub_shift_iter.sv
// Iterative InvShiftRows + InvSubBytes: COLS_PER_CYCLE output columns per busy cycle.
// Optional macro INV_SUB_SHIFT_B2B_EN allows DONE -> BUSY back-to-back acceptance.
module inv_sub_shift_iter #(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);

    logic [1:0]   state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] in_q, in_d;
    logic [127:0] out_q, out_d;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8); maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int unsigned i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] t;
        t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    // Output column c, row r comes from input column (c - r) mod 4 of the same row.
    function automatic logic [31:0] col_xform(input logic [127:0] st, input logic [1:0] c);
        logic [31:0] res;
        logic [1:0]  sc;
        logic [3:0]  k;
        res = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            sc = c - 2'(r);
            k  = {sc, 2'(r)};
            res[{~2'(r), 3'b000} +: 8] = inv_sbox(st[{~k, 3'b000} +: 8]);
        end
        return res;
    endfunction

    always_comb begin
        logic [1:0] wc;
        wc      = '0;
        state_d = state_q;
        col_d   = col_q;
        in_d    = in_q;
        out_d   = out_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    in_d    = in_state;
                    out_d   = '0;
                    col_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                for (int unsigned j = 0; j < COLS_PER_CYCLE; j++) begin
                    wc = col_q + 2'(j);
                    out_d[{~wc, 5'b00000} +: 32] = col_xform(in_q, wc);
                end
                if (col_q == LAST_COL) begin
                    col_d   = '0;
                    state_d = S_DONE;
                end else begin
                    col_d = col_q + COL_STEP;
                end
            end
            S_DONE: begin
                if (out_ready) begin
`ifdef INV_SUB_SHIFT_B2B_EN
                    if (in_valid) begin
                        in_d    = in_state;
                        out_d   = '0;
                        col_d   = '0;
                        state_d = S_BUSY;
                    end else begin
                        state_d = S_IDLE;
                    end
`else
                    state_d = S_IDLE;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            in_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            in_q    <= in_d;
            out_q   <= out_d;
        end
    end

`ifdef INV_SUB_SHIFT_B2B_EN
    assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
`else
    assign in_ready = (state_q == S_IDLE);
`endif
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_BUSY);
    assign out_state = out_q;

endmodule
